input_dma: RTL

//  Input-load engine for each CNN layer. Receives dma_start from the layer sequencer and burst-reads
//  cfg_len words from external memory starting at cfg_base. Writes them into ping-pong input buffer A or B.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/input_dma.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN-engine encodings (DMA state machine, ping-pong buffer select).
`default_nettype none

package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    REARM = 3'd4
  } dma_state_t;

  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/input_dma.sv
// input_dma: burst-loads cfg_len words from external memory into ping-pong input buffer A or B.
// Optional macro DMA_PERF_CNT_EN adds the dma_cycles busy-cycle counter output.
`default_nettype none

module input_dma
  import cnn_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32,
  parameter int BUF_AW          = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_start,
  input  logic              active_in_buf,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [BUF_AW:0]   cfg_len,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              buf_a_we,
  output logic              buf_b_we,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
`ifdef DMA_PERF_CNT_EN
  output logic [31:0]       dma_cycles,
`endif
  output logic              dma_done
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  dma_state_t        state, state_next;
  logic [ADDR_W-1:0] base;
  logic [BUF_AW:0]   len;
  logic [BUF_AW:0]   req_cnt;
  logic [BUF_AW:0]   rsp_cnt;
  logic [OUT_W-1:0]  outst;
  logic              buf_sel;
  logic              start_fire;
  logic              req_fire;
  logic              rsp_fire;
  logic              in_xfer;

  assign in_xfer       = (state == ISSUE) || (state == DRAIN);
  assign start_fire    = (state == IDLE) && dma_start;
  // Valid only falls on an accept (req_cnt/outst only grow then), so it holds stable while stalled.
  assign mem_req_valid = (state == ISSUE) && (req_cnt < len) && (outst < OUT_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = base + ADDR_W'(req_cnt);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_fire      = mem_rsp_valid && in_xfer;
  assign busy          = in_xfer || (state == DONE);
  assign dma_done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dma_start) state_next = (cfg_len == '0) ? DONE : ISSUE;
      ISSUE:   if (req_cnt == len) state_next = DRAIN;
      // The last write register is set in the same cycle rsp_cnt reaches len.
      DRAIN:   if (rsp_cnt == len) state_next = DONE;
      DONE:    state_next = REARM;
      REARM:   if (!dma_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base    <= '0;
      len     <= '0;
      buf_sel <= BUF_A;
      req_cnt <= '0;
      rsp_cnt <= '0;
      outst   <= '0;
    end else if (start_fire) begin
      base    <= cfg_base;
      len     <= cfg_len;
      buf_sel <= active_in_buf;
      req_cnt <= '0;
      rsp_cnt <= '0;
      outst   <= '0;
    end else begin
      if (req_fire) req_cnt <= req_cnt + 1'b1;
      if (rsp_fire) rsp_cnt <= rsp_cnt + 1'b1;
      case ({req_fire, rsp_fire})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_a_we  <= 1'b0;
      buf_b_we  <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      buf_a_we <= rsp_fire && (buf_sel == BUF_A);
      buf_b_we <= rsp_fire && (buf_sel == BUF_B);
      if (rsp_fire) begin
        buf_waddr <= rsp_cnt[BUF_AW-1:0];
        buf_wdata <= mem_rsp_data;
      end
    end
  end

`ifdef DMA_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             dma_cycles <= '0;
    else if (start_fire)                   dma_cycles <= '0;
    else if (in_xfer && dma_cycles != '1)  dma_cycles <= dma_cycles + 32'd1;
  end
`endif

endmodule

`default_nettype wire
